// File: rtl/l1_pmem_arbiter.sv
// l1_pmem_arbiter: shares one lower-level memory port between the L1 I-cache
// and the L1 D-cache. One transaction is outstanding at a time. Conflicts are
// resolved round-robin, and the request is latched when it is granted.
module l1_pmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // memory side
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;  // 0 = I-cache, 1 = D-cache
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic req_i;
  logic req_d;
  logic grant_i;
  logic grant_d;

  // Round-robin decision: on a tie, the side that was not granted last wins.
  assign req_i   = i_read;
  assign req_d   = d_read | d_write;
  assign grant_d = req_d & (~req_i | ~last_grant);
  assign grant_i = req_i & ~grant_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: grant only from IDLE, return to IDLE on completion
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = SERVE_D;
        end else if (grant_i) begin
          state_nxt = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (m_resp) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winning request at the grant edge; a simultaneous read+write is a write
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= 1'b0;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (state == IDLE) begin
      if (grant_d) begin
        last_grant <= 1'b1;
        op_write   <= d_write;
        addr_q     <= d_addr;
        wdata_q    <= d_wdata;
      end else if (grant_i) begin
        last_grant <= 1'b0;
        op_write   <= 1'b0;
        addr_q     <= i_addr;
      end
    end
  end

  // Output decode. A resp is suppressed while reset is asserted, which abandons the transaction.
  always_comb begin
    m_read  = 1'b0;
    m_write = 1'b0;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    case (state)
      SERVE_I: begin
        m_read  = ~op_write;
        m_write = op_write;
        i_resp  = m_resp & rst;
      end
      SERVE_D: begin
        m_read  = ~op_write;
        m_write = op_write;
        d_resp  = m_resp & rst;
      end
      default: ;
    endcase
  end

  // Latched request toward memory; read data passes straight through to both caches
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_l1_pmem_arbiter.sv
// Testbench for l1_pmem_arbiter: directed sequences, a cycle vector table,
// and randomized traffic checked against a transaction-level ownership model.
`timescale 1ns/1ps
module tb_l1_pmem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_resp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l1_pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_resp(m_resp)
  );

  typedef struct {
    logic [3:0] in;    // {i_read, d_read, d_write, m_resp}
    logic [3:0] exp;   // {m_read, m_write, i_resp, d_resp}
    logic [1:0] asel;  // expected m_addr: 0 = reset value, 1 = I addr, 2 = D addr
  } vec_t;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; m_resp = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    v = '0;
    for (int k = 0; k < int'(LINE_W / 32); k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  localparam logic [LINE_W-1:0] LINE_AA = {(LINE_W/8){8'hAA}};
  localparam logic [LINE_W-1:0] LINE_55 = {(LINE_W/8){8'h55}};
  localparam logic [ADDR_W-1:0] T_IADDR = 32'h0000_1100;
  localparam logic [ADDR_W-1:0] T_DADDR = 32'h0000_2200;

  vec_t vecs[15];

  // reference model state for random traffic
  int                owner;     // 0 none, 1 I-cache, 2 D-cache
  logic              mdl_last;  // 0 = I granted last, 1 = D granted last
  logic              mdl_wr;
  logic [ADDR_W-1:0] mdl_addr;
  logic [LINE_W-1:0] mdl_wdata;
  logic              i_pend, d_pend, i_done, d_done;
  logic              mem_busy;
  int                mem_cnt;
  int                op;
  logic              rq_i, rq_d;

  initial begin
    vecs[0]  = '{4'b1100, 4'b0000, 2'd0};
    vecs[1]  = '{4'b1100, 4'b1000, 2'd2};
    vecs[2]  = '{4'b1101, 4'b1001, 2'd2};
    vecs[3]  = '{4'b1100, 4'b0000, 2'd2};
    vecs[4]  = '{4'b1100, 4'b1000, 2'd1};
    vecs[5]  = '{4'b1101, 4'b1010, 2'd1};
    vecs[6]  = '{4'b1100, 4'b0000, 2'd1};
    vecs[7]  = '{4'b1101, 4'b1001, 2'd2};
    vecs[8]  = '{4'b1100, 4'b0000, 2'd2};
    vecs[9]  = '{4'b1101, 4'b1010, 2'd1};
    vecs[10] = '{4'b0110, 4'b0000, 2'd1};
    vecs[11] = '{4'b0110, 4'b0100, 2'd2};
    vecs[12] = '{4'b0001, 4'b0101, 2'd2};
    vecs[13] = '{4'b0001, 4'b0000, 2'd2};
    vecs[14] = '{4'b0000, 4'b0000, 2'd2};

    // reset held with a pending I read
    rst = 1'b0; i_read = 1'b1; i_addr = 32'h0000_0040;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    m_rdata = '0; m_resp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #2;
      chk1("rst m_read", m_read, 1'b0);
      chk1("rst i_resp", i_resp, 1'b0);
    end
    chkw("rst m_addr", LINE_W'(m_addr), '0);
    rst = 1'b1;
    tick(); m_resp = 1'b1; #1;
    chk1("post-rst m_read", m_read, 1'b1);
    chkw("post-rst m_addr", LINE_W'(m_addr), LINE_W'(32'h0000_0040));
    chk1("post-rst i_resp", i_resp, 1'b1);
    tick(); i_read = 1'b0; m_resp = 1'b0; #1;
    chk1("post-rst idle m_read", m_read, 1'b0);

    // lone I read with five-cycle memory latency
    tick(); i_read = 1'b1; i_addr = 32'h1000_0020; #1;
    chk1("iread idle m_read", m_read, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick(); m_resp = (k == 5); m_rdata = (k == 5) ? LINE_AA : '0; #1;
      chk1($sformatf("iread c%0d m_read", k), m_read, 1'b1);
      chk1($sformatf("iread c%0d m_write", k), m_write, 1'b0);
      chk1($sformatf("iread c%0d i_resp", k), i_resp, k == 5);
      chk1($sformatf("iread c%0d d_resp", k), d_resp, 1'b0);
      chkw($sformatf("iread c%0d m_addr", k), LINE_W'(m_addr), LINE_W'(32'h1000_0020));
    end
    chkw("iread i_rdata", i_rdata, LINE_AA);
    tick(); i_read = 1'b0; m_resp = 1'b0; #1;
    chk1("iread done m_read", m_read, 1'b0);

    // D writeback: data latched at grant, later changes ignored
    tick(); d_write = 1'b1; d_addr = 32'h2000_0000; d_wdata = LINE_55; #1;
    chk1("dwr idle m_write", m_write, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick(); if (k == 1) d_wdata = '0; m_resp = (k == 3); #1;
      chk1($sformatf("dwr c%0d m_write", k), m_write, 1'b1);
      chk1($sformatf("dwr c%0d m_read", k), m_read, 1'b0);
      chkw($sformatf("dwr c%0d m_wdata", k), m_wdata, LINE_55);
      chkw($sformatf("dwr c%0d m_addr", k), LINE_W'(m_addr), LINE_W'(32'h2000_0000));
      chk1($sformatf("dwr c%0d d_resp", k), d_resp, k == 3);
    end
    tick(); d_write = 1'b0; m_resp = 1'b0; #1;
    chk1("dwr after d_resp", d_resp, 1'b0);
    chk1("dwr after m_write", m_write, 1'b0);

    // table: tie-breaking, alternation, read+write as write, stray m_resp in IDLE
    do_reset();
    i_addr = T_IADDR; d_addr = T_DADDR;
    for (int r = 0; r < 15; r++) begin
      tick();
      {i_read, d_read, d_write, m_resp} = vecs[r].in;
      #1;
      chk1($sformatf("vec%0d m_read", r), m_read, vecs[r].exp[3]);
      chk1($sformatf("vec%0d m_write", r), m_write, vecs[r].exp[2]);
      chk1($sformatf("vec%0d i_resp", r), i_resp, vecs[r].exp[1]);
      chk1($sformatf("vec%0d d_resp", r), d_resp, vecs[r].exp[0]);
      chkw($sformatf("vec%0d m_addr", r), LINE_W'(m_addr),
           (vecs[r].asel == 2'd1) ? LINE_W'(T_IADDR) : (vecs[r].asel == 2'd2) ? LINE_W'(T_DADDR) : '0);
    end

    // reset during SERVE_D with m_resp in the same cycle
    do_reset();
    tick(); d_read = 1'b1; d_addr = 32'h3000_0000; #1;
    chk1("rstmid idle m_read", m_read, 1'b0);
    tick(); #1;
    chk1("rstmid serve m_read", m_read, 1'b1);
    tick(); rst = 1'b0; m_resp = 1'b1; #1;
    chk1("rstmid d_resp", d_resp, 1'b0);
    chk1("rstmid i_resp", i_resp, 1'b0);
    tick(); rst = 1'b1; m_resp = 1'b0; i_read = 1'b1; i_addr = 32'h4000_0000;
    d_read = 1'b1; d_addr = 32'h3000_0040; #1;
    chk1("rstmid next m_read", m_read, 1'b0);
    tick(); #1;
    chk1("rstmid tie m_read", m_read, 1'b1);
    chkw("rstmid tie m_addr", LINE_W'(m_addr), LINE_W'(32'h3000_0040));

    // randomized traffic against the ownership model
    do_reset();
    owner = 0; mdl_last = 1'b0; mdl_wr = 1'b0; mdl_addr = '0; mdl_wdata = '0;
    i_pend = 1'b0; d_pend = 1'b0; i_done = 1'b0; d_done = 1'b0; mem_busy = 1'b0; mem_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (i_done) begin
        i_read = 1'b0; i_pend = 1'b0;
      end else if (!i_pend && $urandom_range(0, 3) == 0) begin
        i_read = 1'b1; i_addr = $urandom & 32'hFFFF_FFE0; i_pend = 1'b1;
      end
      if (d_done) begin
        d_read = 1'b0; d_write = 1'b0; d_pend = 1'b0;
      end else if (!d_pend && $urandom_range(0, 3) == 0) begin
        op = $urandom_range(0, 2);
        d_read = (op != 1); d_write = (op != 0);
        d_addr = $urandom & 32'hFFFF_FFE0; d_pend = 1'b1;
      end
      d_wdata = rand_line();
      m_rdata = rand_line();
      if (m_read | m_write) begin
        if (!mem_busy) begin mem_busy = 1'b1; mem_cnt = $urandom_range(0, 4); end
        if (mem_cnt == 0) begin m_resp = 1'b1; mem_busy = 1'b0; end
        else begin m_resp = 1'b0; mem_cnt--; end
      end else begin
        mem_busy = 1'b0;
        m_resp = ($urandom_range(0, 15) == 0);
      end
      #1;
      i_done = 1'b0; d_done = 1'b0;
      chkw("rnd i_rdata", i_rdata, m_rdata);
      chkw("rnd d_rdata", d_rdata, m_rdata);
      chkw("rnd m_addr", LINE_W'(m_addr), LINE_W'(mdl_addr));
      chkw("rnd m_wdata", m_wdata, mdl_wdata);
      if (owner != 0) begin
        chk1("rnd m_read", m_read, ~mdl_wr);
        chk1("rnd m_write", m_write, mdl_wr);
        chk1("rnd i_resp", i_resp, m_resp && owner == 1);
        chk1("rnd d_resp", d_resp, m_resp && owner == 2);
        if (m_resp) begin
          i_done = (owner == 1); d_done = (owner == 2);
          owner = 0;
        end
      end else begin
        chk1("rnd idle m_read", m_read, 1'b0);
        chk1("rnd idle m_write", m_write, 1'b0);
        chk1("rnd idle i_resp", i_resp, 1'b0);
        chk1("rnd idle d_resp", d_resp, 1'b0);
        rq_i = i_read; rq_d = d_read | d_write;
        if (rq_d && (!rq_i || !mdl_last)) begin
          owner = 2; mdl_last = 1'b1; mdl_wr = d_write; mdl_addr = d_addr; mdl_wdata = d_wdata;
        end else if (rq_i) begin
          owner = 1; mdl_last = 1'b0; mdl_wr = 1'b0; mdl_addr = i_addr;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_pmem_arbiter.md
Name: l1_pmem_arbiter

Overview:
- Shares the single lower-level memory port (L2 or physical memory) between the L1 instruction cache and the L1 data cache.
- Each L1 cache_control issues whole-line reads (allocate) and, for the data cache only, whole-line writes (writeback). The arbiter serialises these into one outstanding transaction at a time.
- Arbitration is round-robin on conflict. Address, write data and operation are latched at grant. The response is routed back to the granted requester only.

Parameters:
- ADDR_W, 32, byte address width; line-aligned addresses are passed through unchanged.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset: sampled on posedge clk, rst==0 resets.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line data to I-cache.
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line read request (allocate).
- d_write  in  1  D-cache line write request (writeback).
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  D-cache writeback data.
- d_rdata  out  LINE_W  line data to D-cache.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- m_read  out  1  memory read strobe, held until m_resp.
- m_write  out  1  memory write strobe, held until m_resp.
- m_addr  out  ADDR_W  memory address (latched).
- m_wdata  out  LINE_W  memory write data (latched).
- m_rdata  in  LINE_W  memory read data, valid with m_resp.
- m_resp  in  1  memory completion, one cycle.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Registers:
  - state
  - last_grant (0 = I, 1 = D)
  - op_write
  - addr_q
  - wdata_q
- Reset (rst==0 at posedge):
  - state = IDLE, last_grant = 0, op_write = 0, addr_q = 0, wdata_q = 0.
  - All outputs 0 from the following cycle onward: m_read, m_write, i_resp, d_resp; m_addr = 0, m_wdata = 0.
  - i_rdata and d_rdata are pure pass-throughs of m_rdata and are not affected by reset.
- Reset mid-transaction abandons it; no resp is issued to either requester.
- IDLE:
  - m_read = m_write = 0.
  - req_i = i_read; req_d = d_read | d_write.
  - Only req_i: next state SERVE_I, addr_q <= i_addr, op_write <= 0.
  - Only req_d: next state SERVE_D, addr_q <= d_addr, wdata_q <= d_wdata, op_write <= d_write.
  - Both: grant the requester that is not last_grant (last_grant 0 -> D wins; 1 -> I wins).
  - last_grant <= granted requester at the grant edge.
  - d_read and d_write both high: treated as a write (op_write = 1).
  - m_resp is ignored in IDLE.
- SERVE_I / SERVE_D:
  - m_read = ~op_write; m_write = op_write.
  - m_addr = addr_q; m_wdata = wdata_q.
  - Outputs are held stable regardless of requester inputs.
- Completion: on m_resp==1 in SERVE_x, x_resp = 1 in the same cycle (combinational from m_resp and state). Next state is IDLE.
- i_rdata = d_rdata = m_rdata at all times; the resp pulse qualifies the data.
- The other resp is 0 at all times except during its own serve state.
- Latency: a request seen in IDLE at edge N drives m_read/m_write in cycle N+1.
  - x_resp coincides with m_resp.
  - Total latency = memory latency + 1 cycle.
- After a completion, at least one IDLE cycle is spent before the next grant. A requester that deasserts on resp is therefore never re-granted.
- If a requester drops its request mid-serve, the transaction still completes and its resp pulses; the requester must ignore it.
- Requests arriving during a serve wait in IDLE arbitration; no queueing beyond the held request.
- Starvation-free: when both requesters continuously request, grants strictly alternate.

Test Plan:
1. Reset with rst=0 for 2 cycles while i_read=1 -> m_read=0, i_resp=0 throughout. After rst=1, m_read=1 with m_addr=i_addr (0x0000_0040) one cycle later.
2. Lone I read, addr 0x1000_0020, memory responds after 5 cycles with rdata=0xAA..AA:
   - m_read high for 5 cycles, m_write stays 0.
   - i_resp=1 and i_rdata=0xAA..AA in the m_resp cycle; d_resp=0.
3. D write, addr 0x2000_0000, wdata 0x55..55; d_wdata changed to 0 one cycle after grant -> m_write=1, m_wdata stays 0x55..55 until m_resp, then d_resp pulses once.
4. i_read and d_read rise in the same cycle after reset -> D served first. I is served immediately after, with one IDLE cycle between. Repeat with both held -> grants alternate D, I, D, I.
5. d_read=d_write=1 simultaneously -> m_write=1, m_read=0.
6. Assert rst=0 mid SERVE_D with m_resp arriving that same cycle -> no d_resp. State IDLE next cycle; last_grant=0 (next tie goes to D).
